expr_result_misr: RTL and testbench
===================================

Name: expr_result_misr

Overview:
- Downstream consumer of the 90-bit concatenated result bus `y` from an expression-under-test block.
- Accepts one result per valid/ready handshake and folds each result into a SIG_WIDTH multiple-input signature register (MISR).
- Counts accepted samples and stops after a programmed number of samples.
- Reports the final signature and a pass/fail compare against a golden value supplied by the bench or a host.

Parameters:
- Y_WIDTH, 90, width of the result bus under test.
- SIG_WIDTH, 32, width of the signature register.
- CNT_WIDTH, 16, width of the sample counter and of num_samples.
- POLY, 32'h04C11DB7, MISR feedback polynomial (SIG_WIDTH bits).
- SEED, 32'hFFFFFFFF, signature value loaded on start.

Ports:
- clk, in, 1, sole clock; all state updates on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, single-cycle request to begin a run.
- num_samples, in, CNT_WIDTH, results to absorb; sampled on an accepted start.
- golden_sig, in, SIG_WIDTH, expected signature; compared combinationally in DONE.
- y_valid, in, 1, upstream result valid.
- y_ready, out, 1, consumer ready.
- y, in, Y_WIDTH, result bus.
- busy, out, 1, high in RUN.
- done, out, 1, high in DONE.
- match, out, 1, done && (signature == golden_sig).
- signature, out, SIG_WIDTH, current MISR value.
- sample_count, out, CNT_WIDTH, results accepted in the current run.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, signature=SEED, sample_count=0, target=0. Outputs y_ready=0, busy=0, done=0, match=0.
- Fold (combinational):
  - Zero-pad y to K*SIG_WIDTH, where K = ceil(Y_WIDTH/SIG_WIDTH). K=3 for defaults, so the top slice is {6'b0, y[89:64]}.
  - fold = XOR of the K slices.
- MISR step: sig_next = {sig[SIG_WIDTH-2:0], 1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : 0) ^ fold.
- Accept = y_valid && y_ready. y_ready = (state==RUN), driven from a register-decoded state only; it has no combinational path from y_valid.
- State IDLE:
  - start=1 loads signature=SEED, sample_count=0, target=num_samples.
  - Next state is RUN if num_samples!=0, else DONE.
- State RUN:
  - On each accept: signature<=sig_next, sample_count<=sample_count+1.
  - On the accept where sample_count==target-1, next state is DONE.
  - No accept: all registers hold.
  - start is ignored in RUN.
- State DONE:
  - Registers hold; done=1; y_ready=0.
  - start=1 behaves exactly as in IDLE (re-seed and restart).
  - No transition back to IDLE except by reset.
- Latency: the signature reflects an accepted sample on the clock edge that accepts it. done rises the cycle after the final accept.
- Wrap-around:
  - sample_count never exceeds target; the max target of 2^CNT_WIDTH-1 is legal.
  - num_samples=0 produces DONE with signature=SEED one cycle after start.
- Reset mid-run: returns immediately to the reset values, and any in-flight handshake is dropped. Upstream must treat y_ready=0 as no acceptance.
- Simultaneous start and y_valid in IDLE/DONE: y_ready is 0 that cycle, so no sample is accepted; start wins.
- y_valid may toggle freely; y is only sampled on an accept.

Decomposition:
- Shared package expr_tb_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default POLY and SEED constants;
  - the function computing K from Y_WIDTH/SIG_WIDTH.
- One sub-module, misr_fold_step: purely combinational, computes fold and sig_next from (sig, y), parameterised by Y_WIDTH, SIG_WIDTH, POLY.
- The top level holds the FSM, the counters and the registers.

Test Plan:
- Reset/zero-length: assert rst, release; start with num_samples=0 → done=1 next cycle, signature=32'hFFFFFFFF, sample_count=0, y_ready never high.
- Single zero sample: start, num_samples=1, y=0 with y_valid held → one accept; signature=32'hFB3EE249, done=1 the following cycle. With golden_sig=32'hFB3EE249, match=1.
- Backpressure/gaps: num_samples=3, y_valid pulsed with 2-cycle gaps, y=90'h1 each time → exactly 3 accepts; signature equals the reference model after 3 steps of fold=32'h1; sample_count steps 1,2,3.
- Fold padding: y with only bit 89 set → fold=32'h02000000; confirm the single-step signature matches the model; bits beyond Y_WIDTH have no effect.
- Start ignored in RUN: pulse start mid-run with num_samples=5 → target, count and signature are unaffected; run finishes after 5 accepts.
- Async reset mid-run: assert rst between clock edges after 2 of 4 samples → outputs return to reset values immediately. A following start with num_samples=1 and y=0 again yields 32'hFB3EE249.

Source files
------------

// File: rtl/expr_tb_pkg.sv
// Shared types and constants for the expression-result MISR checker.
package expr_tb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } misr_state_e;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF;

    // Number of SIG_WIDTH slices needed to cover a Y_WIDTH bus.
    function automatic int calc_k(input int y_width, input int sig_width);
        return (y_width + sig_width - 1) / sig_width;
    endfunction

endpackage

// File: rtl/misr_fold_step.sv
// Combinational MISR step: XOR-folds the padded result bus and advances the signature.
module misr_fold_step
    import expr_tb_pkg::*;
#(
    parameter int                   Y_WIDTH   = 90,
    parameter int                   SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0] POLY      = DEFAULT_POLY
) (
    input  logic [SIG_WIDTH-1:0] sig_i,
    input  logic [Y_WIDTH-1:0]   y_i,
    output logic [SIG_WIDTH-1:0] sig_next_o
);

    localparam int K = calc_k(Y_WIDTH, SIG_WIDTH);

    logic [K*SIG_WIDTH-1:0] y_pad;
    logic [SIG_WIDTH-1:0]   fold;

    always_comb begin
        y_pad                = '0;
        y_pad[Y_WIDTH-1:0]   = y_i;
        fold                 = '0;
        for (int k = 0; k < K; k++) begin
            fold = fold ^ y_pad[k*SIG_WIDTH +: SIG_WIDTH];
        end
    end

    always_comb begin
        sig_next_o = {sig_i[SIG_WIDTH-2:0], 1'b0}
                   ^ (sig_i[SIG_WIDTH-1] ? POLY : '0)
                   ^ fold;
    end

endmodule

// File: rtl/expr_result_misr.sv
// Result-bus signature collector: absorbs a programmed number of handshaked
// results into a MISR and compares the final signature against a golden value.
module expr_result_misr
    import expr_tb_pkg::*;
#(
    parameter int                   Y_WIDTH   = 90,
    parameter int                   SIG_WIDTH = 32,
    parameter int                   CNT_WIDTH = 16,
    parameter logic [SIG_WIDTH-1:0] POLY      = DEFAULT_POLY,
    parameter logic [SIG_WIDTH-1:0] SEED      = DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_samples,
    input  logic [SIG_WIDTH-1:0] golden_sig,
    input  logic                 y_valid,
    output logic                 y_ready,
    input  logic [Y_WIDTH-1:0]   y,
    output logic                 busy,
    output logic                 done,
    output logic                 match,
    output logic [SIG_WIDTH-1:0] signature,
    output logic [CNT_WIDTH-1:0] sample_count
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // RUN   | accepting results until target reached
    // DONE  | signature final; start re-seeds and restarts

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    misr_state_e          state_q,  state_d;
    logic [SIG_WIDTH-1:0] sig_q,    sig_d;
    logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
    logic [CNT_WIDTH-1:0] target_q, target_d;
    logic [SIG_WIDTH-1:0] sig_next;
    logic                 accept;

    misr_fold_step #(
        .Y_WIDTH   (Y_WIDTH),
        .SIG_WIDTH (SIG_WIDTH),
        .POLY      (POLY)
    ) u_step (
        .sig_i      (sig_q),
        .y_i        (y),
        .sig_next_o (sig_next)
    );

    // Ready decodes only the state register, so it never depends on y_valid.
    assign y_ready = (state_q == RUN);
    assign accept  = y_valid && y_ready;

    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sig_d    = SEED;
                    cnt_d    = '0;
                    target_d = num_samples;
                    state_d  = (num_samples != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (accept) begin
                    sig_d = sig_next;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == target_q - CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sig_q    <= SEED;
            cnt_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign match        = done && (sig_q == golden_sig);
    assign signature    = sig_q;
    assign sample_count = cnt_q;

endmodule

// File: tb/tb_expr_result_misr.sv
// Directed bench for expr_result_misr with hand-computed signatures.
module tb_expr_result_misr;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_samples;
    logic [31:0] golden_sig;
    logic        y_valid;
    logic        y_ready;
    logic [89:0] y;
    logic        busy;
    logic        done;
    logic        match;
    logic [31:0] signature;
    logic [15:0] sample_count;

    int checks = 0;
    int errors = 0;

    expr_result_misr dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_samples  (num_samples),
        .golden_sig   (golden_sig),
        .y_valid      (y_valid),
        .y_ready      (y_ready),
        .y            (y),
        .busy         (busy),
        .done         (done),
        .match        (match),
        .signature    (signature),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sig"},   64'(signature),    64'hFFFFFFFF);
        check({tag, "_cnt"},   64'(sample_count), 64'h0);
        check({tag, "_ready"}, 64'(y_ready),      64'h0);
        check({tag, "_busy"},  64'(busy),         64'h0);
        check({tag, "_done"},  64'(done),         64'h0);
        check({tag, "_match"}, 64'(match),        64'h0);
    endtask

    logic [31:0] exp_gap [3];

    initial begin
        exp_gap[0] = 32'hFB3EE248;
        exp_gap[1] = 32'hF2BCD926;
        exp_gap[2] = 32'hE1B8AFFA;

        rst         = 1'b1;
        start       = 1'b0;
        num_samples = '0;
        golden_sig  = 32'hFFFFFFFF;
        y_valid     = 1'b0;
        y           = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // zero-length run
        start = 1'b1; num_samples = 16'd0;
        @(negedge clk);
        start = 1'b0;
        check("zl_done",  64'(done),         64'h1);
        check("zl_sig",   64'(signature),    64'hFFFFFFFF);
        check("zl_cnt",   64'(sample_count), 64'h0);
        check("zl_ready", 64'(y_ready),      64'h0);
        check("zl_match", 64'(match),        64'h1);

        // single zero sample; start with y_valid high must not accept
        start = 1'b1; num_samples = 16'd1; y = '0; y_valid = 1'b1;
        golden_sig = 32'hFB3EE249;
        @(negedge clk);
        start = 1'b0;
        check("one_busy",    64'(busy),         64'h1);
        check("one_ready",   64'(y_ready),      64'h1);
        check("one_nocnt",   64'(sample_count), 64'h0);
        check("one_noacc",   64'(signature),    64'hFFFFFFFF);
        @(negedge clk);
        check("one_done",    64'(done),         64'h1);
        check("one_sig",     64'(signature),    64'hFB3EE249);
        check("one_cnt",     64'(sample_count), 64'h1);
        check("one_match",   64'(match),        64'h1);
        @(negedge clk);
        check("one_hold",    64'(signature),    64'hFB3EE249);
        y_valid = 1'b0;

        // backpressure with 2-cycle gaps, fold = 1 per sample
        start = 1'b1; num_samples = 16'd3; y = 90'h1; golden_sig = 32'h0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            y_valid = 1'b1;
            @(negedge clk);
            y_valid = 1'b0;
            check($sformatf("gap_cnt%0d", i), 64'(sample_count), 64'(i + 1));
            check($sformatf("gap_sig%0d", i), 64'(signature),    64'(exp_gap[i]));
            @(negedge clk);
            @(negedge clk);
            check($sformatf("gap_hold%0d", i), 64'(sample_count), 64'(i + 1));
        end
        check("gap_done",  64'(done),  64'h1);
        check("gap_match", 64'(match), 64'h0);

        // top slice padding: only bit 89 set folds to bit 25
        start = 1'b1; num_samples = 16'd1; y = '0; y[89] = 1'b1; y_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pad_sig",  64'(signature), 64'hF93EE249);
        check("pad_done", 64'(done),      64'h1);

        // all three slices XOR together: 1^1^1 = 1
        start = 1'b1; y = {26'h1, 32'h1, 32'h1};
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("xor3_sig", 64'(signature), 64'hFB3EE248);

        // start pulse mid-run is ignored
        start = 1'b1; num_samples = 16'd5; y = '0; y_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; num_samples = 16'd2;
        @(negedge clk);
        start = 1'b0;
        check("ign_cnt",  64'(sample_count), 64'h3);
        check("ign_sig",  64'(signature),    64'hE1B8AFFD);
        check("ign_busy", 64'(busy),         64'h1);
        @(negedge clk);
        @(negedge clk);
        check("ign_done", 64'(done),         64'h1);
        check("ign_cnt5", 64'(sample_count), 64'h5);
        check("ign_sig5", 64'(signature),    64'h8BA1992D);

        // async reset after 2 of 4 samples
        start = 1'b1; num_samples = 16'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_cnt2", 64'(sample_count), 64'h2);
        #2 rst = 1'b1;
        #1 check_reset_outputs("arst");
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; num_samples = 16'd1; y = '0; golden_sig = 32'hFB3EE249;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        y_valid = 1'b0;
        check("post_sig",   64'(signature), 64'hFB3EE249);
        check("post_done",  64'(done),      64'h1);
        check("post_match", 64'(match),     64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
